// File: rtl/seq_pkg.sv
// Shared types and sizing helpers for the sequence-memory game datapath.
package seq_pkg;

  localparam int unsigned NUM_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAppend,
    StShowOn,
    StShowOff,
    StWaitKey
  } state_e;

  // Bits needed to hold a count from 0 to max_len inclusive.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing the display on/off phases; expired while the count is zero.
module phase_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/seq_recall_checker.sv
// Sequence-memory game core: grows a random sequence, replays it with timed phases,
// then checks player key presses against it and reports round/game outcome and score.
module seq_recall_checker
  import seq_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned SHOW_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 6_250_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_W-1:0]             rnd_num,
  input  logic                         key_valid,
  input  logic [NUM_W-1:0]             key_num,
  output logic                         show_valid,
  output logic [NUM_W-1:0]             show_num,
  output logic                         awaiting_key,
  output logic                         busy,
  output logic                         round_won,
  output logic                         game_won,
  output logic                         game_over,
  output logic [len_w(MAX_LEN)-1:0]    score
);

  localparam int unsigned LenW = len_w(MAX_LEN);
  localparam int unsigned IdxW = $clog2(MAX_LEN);
  localparam int unsigned TMax = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  state_e state_d, state_q;
  logic [LenW-1:0]  len_d, len_q, score_d, score_q;
  logic [IdxW-1:0]  idx_d, idx_q;
  logic [NUM_W-1:0] mem [MAX_LEN];
  logic             mem_we;
  logic [NUM_W-1:0] rd_num;
  logic             last;
  logic             tmr_load, tmr_expired;
  logic [TW-1:0]    tmr_val;

  logic             show_valid_d, show_valid_q;
  logic [NUM_W-1:0] show_num_d, show_num_q;
  logic             awaiting_d, awaiting_q;
  logic             busy_d, busy_q;
  logic             round_won_d, round_won_q;
  logic             game_won_d, game_won_q;
  logic             game_over_d, game_over_q;

  phase_timer #(
    .Width (TW)
  ) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  assign last = (LenW'(idx_q) == len_q - LenW'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    score_d     = score_q;
    mem_we      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = TW'(SHOW_CYCLES - 1);
    round_won_d = 1'b0;
    game_won_d  = 1'b0;
    game_over_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = '0;
          score_d = '0;
          state_d = StAppend;
        end
      end
      StAppend: begin
        mem_we   = 1'b1;
        len_d    = len_q + LenW'(1);
        idx_d    = '0;
        tmr_load = 1'b1;
        state_d  = StShowOn;
      end
      StShowOn: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES - 1);
          state_d  = StShowOff;
        end
      end
      StShowOff: begin
        if (tmr_expired) begin
          if (last) begin
            idx_d   = '0;
            state_d = StWaitKey;
          end else begin
            idx_d    = idx_q + IdxW'(1);
            tmr_load = 1'b1;
            state_d  = StShowOn;
          end
        end
      end
      StWaitKey: begin
        if (key_valid) begin
          if (key_num != mem[idx_q]) begin
            game_over_d = 1'b1;
            state_d     = StIdle;
          end else if (!last) begin
            idx_d = idx_q + IdxW'(1);
          end else begin
            score_d = score_q + LenW'(1);
            if (len_q == LenW'(MAX_LEN)) begin
              game_won_d = 1'b1;
              state_d    = StIdle;
            end else begin
              round_won_d = 1'b1;
              state_d     = StAppend;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Bypass the write so the first element shows correctly on the cycle it is stored.
    rd_num = (mem_we && (idx_d == len_q[IdxW-1:0])) ? rnd_num : mem[idx_d];

    show_valid_d = (state_d == StShowOn);
    show_num_d   = show_valid_d ? rd_num : '0;
    awaiting_d   = (state_d == StWaitKey);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      idx_q        <= '0;
      score_q      <= '0;
      show_valid_q <= 1'b0;
      show_num_q   <= '0;
      awaiting_q   <= 1'b0;
      busy_q       <= 1'b0;
      round_won_q  <= 1'b0;
      game_won_q   <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      score_q      <= score_d;
      show_valid_q <= show_valid_d;
      show_num_q   <= show_num_d;
      awaiting_q   <= awaiting_d;
      busy_q       <= busy_d;
      round_won_q  <= round_won_d;
      game_won_q   <= game_won_d;
      game_over_q  <= game_over_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[len_q[IdxW-1:0]] <= rnd_num;
    end
  end

  assign show_valid   = show_valid_q;
  assign show_num     = show_num_q;
  assign awaiting_key = awaiting_q;
  assign busy         = busy_q;
  assign round_won    = round_won_q;
  assign game_won     = game_won_q;
  assign game_over    = game_over_q;
  assign score        = score_q;

endmodule

// File: tb/tb_seq_recall_checker.sv
// Bench for seq_recall_checker: scripted and random games checked against a queue-based model.
module tb_seq_recall_checker;

  localparam int MaxLen = 3;
  localparam int Show   = 3;
  localparam int Gap    = 2;
  localparam int Period = Show + Gap;
  localparam int LenW   = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [3:0]      rnd_num = 4'd0;
  logic            key_valid = 1'b0;
  logic [3:0]      key_num = 4'd0;
  logic            show_valid;
  logic [3:0]      show_num;
  logic            awaiting_key;
  logic            busy;
  logic            round_won;
  logic            game_won;
  logic            game_over;
  logic [LenW-1:0] score;

  int n_checks = 0;
  int n_pass   = 0;
  int seq_q[$];
  int model_score = 0;

  always #5 clock = ~clock;

  seq_recall_checker #(
    .MAX_LEN     (MaxLen),
    .SHOW_CYCLES (Show),
    .GAP_CYCLES  (Gap)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rnd_num      (rnd_num),
    .key_valid    (key_valid),
    .key_num      (key_num),
    .show_valid   (show_valid),
    .show_num     (show_num),
    .awaiting_key (awaiting_key),
    .busy         (busy),
    .round_won    (round_won),
    .game_won     (game_won),
    .game_over    (game_over),
    .score        (score)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if ({show_valid, show_num, awaiting_key, busy} !== 7'd0)
      $display("FAIL reset_outputs: got %b want 0", {show_valid, show_num, awaiting_key, busy});
    else n_pass++;
    n_checks++; if ({round_won, game_won, game_over} !== 3'd0)
      $display("FAIL reset_pulses: got %b want 000", {round_won, game_won, game_over});
    else n_pass++;
    n_checks++; if (score !== '0) $display("FAIL reset_score: got %0d want 0", score);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_num   = 4'($urandom_range(15));
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL idle_key_busy: got %b want 0", busy);
      else n_pass++;
      n_checks++; if ({awaiting_key, game_over} !== 2'b00)
        $display("FAIL idle_key_ignored: got %b want 00", {awaiting_key, game_over});
      else n_pass++;
    end
    key_valid = 1'b0;
  endtask

  // One round: optional start, display of the whole model sequence, then key entry.
  // wrong_at < 0 means every key is correct.
  task automatic test_round(input logic [3:0] rnd, input int wrong_at, input bit from_idle,
                            input logic [3:0] wrong_xor, input bit noise, output bit ended);
    int len;
    ended   = 1'b0;
    rnd_num = rnd;
    if (from_idle) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      seq_q.delete();
      model_score = 0;
      n_checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy);
      else n_pass++;
      n_checks++; if (show_valid !== 1'b0) $display("FAIL append_show: got %b want 0", show_valid);
      else n_pass++;
      n_checks++; if (score !== '0) $display("FAIL start_score: got %0d want 0", score);
      else n_pass++;
    end
    seq_q.push_back(int'(rnd));
    len = seq_q.size();

    for (int c = 0; c < len * Period; c++) begin
      bit         v;
      logic [3:0] n;
      v = (c % Period) < Show;
      n = v ? 4'(seq_q[c / Period]) : 4'd0;
      if (noise) begin
        start     = 1'($urandom_range(1));
        key_valid = 1'($urandom_range(1));
        key_num   = 4'($urandom_range(15));
      end
      tick();
      n_checks++; if (show_valid !== v)
        $display("FAIL show_valid c=%0d: got %b want %b", c, show_valid, v);
      else n_pass++;
      n_checks++; if (show_num !== n)
        $display("FAIL show_num c=%0d: got %0d want %0d", c, show_num, n);
      else n_pass++;
      n_checks++; if ({awaiting_key, busy} !== 2'b01)
        $display("FAIL display_status c=%0d: got %b want 01", c, {awaiting_key, busy});
      else n_pass++;
      if (c == 0) begin
        n_checks++; if (round_won !== 1'b0)
          $display("FAIL round_won_width: got %b want 0", round_won);
        else n_pass++;
      end
    end
    start     = 1'b0;
    key_valid = 1'b0;
    tick();
    n_checks++; if ({awaiting_key, show_valid} !== 2'b10)
      $display("FAIL await_rise: got %b want 10", {awaiting_key, show_valid});
    else n_pass++;

    // Keys are presented on consecutive cycles.
    for (int i = 0; i < len; i++) begin
      key_valid = 1'b1;
      key_num   = (i == wrong_at) ? (4'(seq_q[i]) ^ wrong_xor) : 4'(seq_q[i]);
      if (i == wrong_at) start = 1'b1;
      tick();
      if (i == wrong_at) begin
        key_valid = 1'b0;
        start     = 1'b0;
        ended     = 1'b1;
        n_checks++; if (game_over !== 1'b1) $display("FAIL game_over: got %b want 1", game_over);
        else n_pass++;
        n_checks++; if ({busy, awaiting_key, round_won, game_won} !== 4'd0)
          $display("FAIL over_status: got %b want 0000", {busy, awaiting_key, round_won, game_won});
        else n_pass++;
        n_checks++; if (score !== LenW'(model_score))
          $display("FAIL over_score: got %0d want %0d", score, model_score);
        else n_pass++;
        break;
      end
      if (i < len - 1) begin
        n_checks++; if ({awaiting_key, round_won, game_won, game_over} !== 4'b1000)
          $display("FAIL mid_key i=%0d: got %b want 1000", i,
                   {awaiting_key, round_won, game_won, game_over});
        else n_pass++;
      end else begin
        key_valid = 1'b0;
        model_score++;
        if (len == MaxLen) begin
          ended = 1'b1;
          n_checks++; if ({game_won, round_won, busy} !== 3'b100)
            $display("FAIL game_won: got %b want 100", {game_won, round_won, busy});
          else n_pass++;
        end else begin
          n_checks++; if ({round_won, game_won, busy, awaiting_key} !== 4'b1010)
            $display("FAIL round_won: got %b want 1010", {round_won, game_won, busy, awaiting_key});
          else n_pass++;
        end
        n_checks++; if (score !== LenW'(model_score))
          $display("FAIL win_score: got %0d want %0d", score, model_score);
        else n_pass++;
      end
    end
    key_valid = 1'b0;

    if (ended) begin
      tick();
      n_checks++; if ({busy, show_valid, game_won, game_over} !== 4'd0)
        $display("FAIL after_end: got %b want 0000", {busy, show_valid, game_won, game_over});
      else n_pass++;
      n_checks++; if (score !== LenW'(model_score))
        $display("FAIL end_score_hold: got %0d want %0d", score, model_score);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ended;
    test_round(4'd5, -1, 1'b1, 4'd0, 1'b0, ended);
    rnd_num = 4'd9;
    tick();
    n_checks++; if ({show_valid, show_num} !== {1'b1, 4'd5})
      $display("FAIL mid_show: got %b/%0d want 1/5", show_valid, show_num);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({show_valid, show_num, awaiting_key, busy, round_won, game_won, game_over}
                    !== 10'd0)
      $display("FAIL mid_reset: got %b want 0", {show_valid, show_num, awaiting_key, busy,
                                                 round_won, game_won, game_over});
    else n_pass++;
    n_checks++; if (score !== '0) $display("FAIL mid_reset_score: got %0d want 0", score);
    else n_pass++;
    test_round(4'd11, -1, 1'b1, 4'd0, 1'b0, ended);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 8; g++) begin
      bit ended;
      ended = 1'b0;
      for (int r = 0; r < MaxLen && !ended; r++) begin
        int wrong;
        wrong = ($urandom_range(3) == 0) ? int'($urandom_range(r)) : -1;
        test_round(4'($urandom_range(15)), wrong, r == 0, 4'(1 + $urandom_range(14)), 1'b1, ended);
      end
    end
  endtask

  initial begin
    bit ended;
    test_reset();
    test_round(4'd5, -1, 1'b1, 4'd0, 1'b0, ended);
    test_round(4'd9, -1, 1'b0, 4'd0, 1'b0, ended);
    test_round(4'd2, -1, 1'b0, 4'd0, 1'b0, ended);
    test_round(4'd7, 0, 1'b1, 4'd3, 1'b1, ended);
    test_reset_mid();
    test_random_games();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
